// File: rtl/bonus_effect_pkg.sv
// Shared types and widths for the per-tank bonus shield timer.
package bonus_effect_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, WARN} bonus_state_t;

    localparam int unsigned SEC_W   = 5;
    localparam int unsigned FRAME_W = 6;
    localparam int unsigned STACK_W = 2;

endpackage

// File: rtl/bonus_effect_channel.sv
// One tank's shield effect: frame-tick countdown, stacked extensions, flashing warning phase.
module bonus_effect_channel
    import bonus_effect_pkg::*;
#(
    parameter int unsigned EFFECT_SEC   = 10,
    parameter int unsigned WARN_SEC     = 3,
    parameter int unsigned SOF_PER_SEC  = 30,
    parameter int unsigned MAX_STACK    = 3,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start_of_frame,
    input  logic               bonusIn,
    input  logic               hit,
    output logic               shield,
    output logic               shieldFx,
    output logic [SEC_W-1:0]   secLeft,
    output logic [STACK_W-1:0] stack
);

    localparam logic [1:0] StIdle   = IDLE;
    localparam logic [1:0] StActive = ACTIVE;
    localparam logic [1:0] StWarn   = WARN;

    localparam logic [SEC_W-1:0]   EffSec    = SEC_W'(EFFECT_SEC);
    localparam logic [SEC_W-1:0]   WarnSec   = SEC_W'(WARN_SEC);
    localparam logic [FRAME_W-1:0] FrameLast = FRAME_W'(SOF_PER_SEC - 1);
    localparam logic [FRAME_W-1:0] FlashLast = FRAME_W'(FLASH_FRAMES - 1);
    localparam logic [STACK_W-1:0] MaxStack  = STACK_W'(MAX_STACK);

    logic [1:0]         state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [FRAME_W-1:0] flash_q, flash_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [STACK_W-1:0] stack_q, stack_d;
    logic               fx_q, fx_d;

    logic               sec_tick;
    logic [SEC_W-1:0]   sec_dec;

    assign sec_tick = start_of_frame && (frame_q == FrameLast);
    assign sec_dec  = (sec_q != '0) ? sec_q - 1'b1 : '0;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        flash_d = flash_q;
        sec_d   = sec_q;
        stack_d = stack_q;
        fx_d    = fx_q;
        case (state_q)
            StIdle: begin
                if (bonusIn) begin
                    state_d = StActive;
                    sec_d   = EffSec;
                    frame_d = '0;
                    flash_d = '0;
                    stack_d = '0;
                    fx_d    = 1'b1;
                end
            end
            default: begin
                if (hit) begin
                    state_d = StIdle;
                    frame_d = '0;
                    flash_d = '0;
                    sec_d   = '0;
                    stack_d = '0;
                    fx_d    = 1'b0;
                end else begin
                    if (start_of_frame) begin
                        frame_d = sec_tick ? '0 : frame_q + 1'b1;
                        if (state_q == StWarn) begin
                            flash_d = (flash_q == FlashLast) ? '0 : flash_q + 1'b1;
                            if (flash_q == FlashLast) fx_d = ~fx_q;
                        end
                    end
                    if (sec_tick && (sec_dec == '0)) begin
                        // A bonus arriving on the expiring tick is spent on the reload itself.
                        flash_d = '0;
                        if (bonusIn || (stack_q != '0)) begin
                            if (!bonusIn) stack_d = stack_q - 1'b1;
                            state_d = StActive;
                            sec_d   = EffSec;
                            fx_d    = 1'b1;
                        end else begin
                            state_d = StIdle;
                            sec_d   = '0;
                            fx_d    = 1'b0;
                        end
                    end else begin
                        if (sec_tick) begin
                            sec_d = sec_dec;
                            if ((state_q == StActive) && (sec_dec <= WarnSec)) begin
                                state_d = StWarn;
                                flash_d = '0;
                                fx_d    = 1'b1;
                            end
                        end
                        if (bonusIn && (stack_q < MaxStack)) stack_d = stack_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            frame_q <= '0;
            flash_q <= '0;
            sec_q   <= '0;
            stack_q <= '0;
            fx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            flash_q <= flash_d;
            sec_q   <= sec_d;
            stack_q <= stack_d;
            fx_q    <= fx_d;
        end
    end

    assign shield   = (state_q != StIdle);
    assign shieldFx = fx_q;
    assign secLeft  = sec_q;
    assign stack    = stack_q;

endmodule

// File: rtl/bonus_effect_timer.sv
// Two independent tank shield timers driven by election-house bonus pulses.
module bonus_effect_timer
    import bonus_effect_pkg::*;
#(
    parameter int unsigned EFFECT_SEC   = 10,
    parameter int unsigned WARN_SEC     = 3,
    parameter int unsigned SOF_PER_SEC  = 30,
    parameter int unsigned MAX_STACK    = 3,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start_of_frame,
    input  logic               tank1BonusIn,
    input  logic               tank2BonusIn,
    input  logic               tank1Hit,
    input  logic               tank2Hit,
    output logic               tank1Shield,
    output logic               tank2Shield,
    output logic               tank1ShieldFx,
    output logic               tank2ShieldFx,
    output logic [SEC_W-1:0]   tank1SecLeft,
    output logic [SEC_W-1:0]   tank2SecLeft,
    output logic [STACK_W-1:0] tank1Stack,
    output logic [STACK_W-1:0] tank2Stack
);

    bonus_effect_channel #(
        .EFFECT_SEC  (EFFECT_SEC),
        .WARN_SEC    (WARN_SEC),
        .SOF_PER_SEC (SOF_PER_SEC),
        .MAX_STACK   (MAX_STACK),
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_tank1 (
        .clk           (clk),
        .resetN        (resetN),
        .start_of_frame(start_of_frame),
        .bonusIn       (tank1BonusIn),
        .hit           (tank1Hit),
        .shield        (tank1Shield),
        .shieldFx      (tank1ShieldFx),
        .secLeft       (tank1SecLeft),
        .stack         (tank1Stack)
    );

    bonus_effect_channel #(
        .EFFECT_SEC  (EFFECT_SEC),
        .WARN_SEC    (WARN_SEC),
        .SOF_PER_SEC (SOF_PER_SEC),
        .MAX_STACK   (MAX_STACK),
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_tank2 (
        .clk           (clk),
        .resetN        (resetN),
        .start_of_frame(start_of_frame),
        .bonusIn       (tank2BonusIn),
        .hit           (tank2Hit),
        .shield        (tank2Shield),
        .shieldFx      (tank2ShieldFx),
        .secLeft       (tank2SecLeft),
        .stack         (tank2Stack)
    );

endmodule

// File: tb/tb_bonus_effect_timer.sv
// Bench for bonus_effect_timer: directed scenarios plus random traffic against an elapsed-frame model.
module tb_bonus_effect_timer;

    localparam int EFF   = 4;
    localparam int WARN  = 2;
    localparam int SOF   = 2;
    localparam int MAXS  = 2;
    localparam int FLASH = 1;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       sof = 1'b0, b1 = 1'b0, b2 = 1'b0, h1 = 1'b0, h2 = 1'b0;
    logic       sh1, sh2, fx1, fx2;
    logic [4:0] sec1, sec2;
    logic [1:0] stk1, stk2;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    // Model: per tank, active flag, frames elapsed in the current segment, queued extensions.
    bit m_act[2];
    int m_e[2];
    int m_stk[2];

    int sec_exp1[8] = '{4, 3, 3, 2, 2, 1, 1, 0};
    int fx_exp1[8]  = '{1, 1, 1, 1, 0, 1, 0, 0};

    bonus_effect_timer #(
        .EFFECT_SEC  (EFF),
        .WARN_SEC    (WARN),
        .SOF_PER_SEC (SOF),
        .MAX_STACK   (MAXS),
        .FLASH_FRAMES(FLASH)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .start_of_frame(sof),
        .tank1BonusIn  (b1),
        .tank2BonusIn  (b2),
        .tank1Hit      (h1),
        .tank2Hit      (h2),
        .tank1Shield   (sh1),
        .tank2Shield   (sh2),
        .tank1ShieldFx (fx1),
        .tank2ShieldFx (fx2),
        .tank1SecLeft  (sec1),
        .tank2SecLeft  (sec2),
        .tank1Stack    (stk1),
        .tank2Stack    (stk2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int exp_sec(input int ch);
        return m_act[ch] ? EFF - m_e[ch] / SOF : 0;
    endfunction

    function automatic int exp_fx(input int ch);
        if (!m_act[ch]) return 0;
        if (m_e[ch] < (EFF - WARN) * SOF) return 1;
        return (((m_e[ch] - (EFF - WARN) * SOF) / FLASH) % 2 == 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_act[ch] = 1'b0;
                m_e[ch]   = 0;
                m_stk[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                bit b, h;
                b = (ch == 0) ? b1 : b2;
                h = (ch == 0) ? h1 : h2;
                if (!m_act[ch]) begin
                    if (b) begin
                        m_act[ch] = 1'b1;
                        m_e[ch]   = 0;
                        m_stk[ch] = 0;
                    end
                end else if (h) begin
                    m_act[ch] = 1'b0;
                    m_e[ch]   = 0;
                    m_stk[ch] = 0;
                end else begin
                    if (sof) m_e[ch]++;
                    if (m_e[ch] == EFF * SOF) begin
                        m_e[ch] = 0;
                        if (!b) begin
                            if (m_stk[ch] > 0) m_stk[ch]--;
                            else m_act[ch] = 1'b0;
                        end
                    end else if (b && m_stk[ch] < MAXS) begin
                        m_stk[ch]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_shield1", int'(sh1), int'(m_act[0]));
            check("model_shield2", int'(sh2), int'(m_act[1]));
            check("model_sec1", int'(sec1), exp_sec(0));
            check("model_sec2", int'(sec2), exp_sec(1));
            check("model_fx1", int'(fx1), exp_fx(0));
            check("model_fx2", int'(fx2), exp_fx(1));
            check("model_stack1", int'(stk1), m_stk[0]);
            check("model_stack2", int'(stk2), m_stk[1]);
        end
    end

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic step(input logic s, input logic bb1, input logic bb2,
                        input logic hh1, input logic hh2);
        @(negedge clk);
        sof = s; b1 = bb1; b2 = bb2; h1 = hh1; h2 = hh2;
        @(posedge clk);
        #1;
        sof = 1'b0; b1 = 1'b0; b2 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 resetN = 1'b0;
        #12;
        check("reset_shield1", int'(sh1), 0);
        check("reset_sec1", int'(sec1), 0);
        check("reset_fx2", int'(fx2), 0);
        @(negedge clk);
        resetN = 1'b1;
        chk_en = 1'b1;

        // 1: single bonus, 8 ticks
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_load_shield", int'(sh1), 1);
        check("t1_load_sec", int'(sec1), 4);
        check("t1_load_fx", int'(fx1), 1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("t1_sec_tick%0d", k + 1), int'(sec1), sec_exp1[k]);
            check($sformatf("t1_fx_tick%0d", k + 1), int'(fx1), fx_exp1[k]);
            check($sformatf("t1_shield_tick%0d", k + 1), int'(sh1), (k < 7) ? 1 : 0);
            check($sformatf("t1_tank2_tick%0d", k + 1), int'({sh2, fx2, sec2, stk2}), 0);
        end

        // 2: stacking saturates at 2, 24 ticks total
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("t2_stack_b%0d", k), int'(stk1), (k < 2) ? k : 2);
        end
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 8 || k == 16) begin
                check($sformatf("t2_reload_sec%0d", k), int'(sec1), 4);
                check($sformatf("t2_reload_stack%0d", k), int'(stk1), (k == 8) ? 1 : 0);
            end
            if (k == 23) check("t2_shield_23", int'(sh1), 1);
            if (k == 24) check("t2_shield_24", int'(sh1), 0);
        end

        // 3: bonus on the expiring tick
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(7);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_sec", int'(sec1), 4);
        check("t3_shield", int'(sh1), 1);
        check("t3_stack", int'(stk1), 0);
        check("t3_fx", int'(fx1), 1);
        ticks(8);
        check("t3_drain", int'(sh1), 0);

        // 4: hit with bonus while stacked
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_stack_pre", int'(stk1), 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t4_shield", int'(sh1), 0);
        check("t4_fx", int'(fx1), 0);
        check("t4_stack", int'(stk1), 0);
        check("t4_sec", int'(sec1), 0);

        // 5: both tanks, tank2 hit at tick 3
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_tank2_cleared", int'(sh2), 0);
        check("t5_tank1_alive", int'(sh1), 1);
        ticks(4);
        check("t5_tank1_tick7", int'(sh1), 1);
        ticks(1);
        check("t5_tank1_tick8", int'(sh1), 0);

        // 6: async reset mid-WARN
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);
        check("t6_pre_shield", int'(sh1), 1);
        #2 resetN = 1'b0;
        #1;
        check("t6_rst_outputs1", int'({sh1, fx1, sec1, stk1}), 0);
        check("t6_rst_outputs2", int'({sh2, fx2, sec2, stk2}), 0);
        @(negedge clk);
        resetN = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_restart_sec", int'(sec1), 4);
        check("t6_restart_shield", int'(sh1), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(1, 0)),
                 1'($urandom_range(11, 0) == 0), 1'($urandom_range(11, 0) == 0),
                 1'($urandom_range(63, 0) == 0), 1'($urandom_range(63, 0) == 0));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/bonus_effect_timer.md
# bonus_effect_timer

Consumer of the election-house bonus pulses: turns each single-cycle `tankNBonus` pulse into a timed per-tank shield effect. It counts in frame ticks (`start_of_frame`), stacks extra bonuses earned while an effect runs, and enters a flashing warning phase before expiry. It sits between the election-house counter and the tank/collision/drawing logic. Its outputs gate damage and drive the shield overlay.

## Interface
- `EFFECT_SEC`, default 10: effect length per bonus, in seconds; must satisfy 1 ≤ WARN_SEC < EFFECT_SEC ≤ 31.
- `WARN_SEC`, default 3: remaining seconds at which the warning (flash) phase starts.
- `SOF_PER_SEC`, default 30: frames per second; range 1..63.
- `MAX_STACK`, default 3: maximum queued extensions per tank; range 0..3.
- `FLASH_FRAMES`, default 8: frames per overlay toggle in the warning phase; range 1..63.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: reset, asynchronous, active-low.
- `start_of_frame` in 1: one-cycle frame tick.
- `tank1BonusIn`, `tank2BonusIn` in 1 each: one-cycle bonus pulses.
- `tank1Hit`, `tank2Hit` in 1 each: one-cycle pulses; the tank was shot, so its effect is cancelled.
- `tank1Shield`, `tank2Shield` out 1 each: effect active (ACTIVE or WARN state).
- `tank1ShieldFx`, `tank2ShieldFx` out 1 each: overlay visibility. 1 in ACTIVE, toggling in WARN, 0 in IDLE.
- `tank1SecLeft`, `tank2SecLeft` out 5 each: whole seconds remaining in the current effect.
- `tank1Stack`, `tank2Stack` out 2 each: queued extensions.

## Operation
The two channels are independent and identical. Each has a 3-state FSM (IDLE, ACTIVE, WARN) and registers `frameCnt` (6b), `secLeft` (5b), `stack` (2b), `flashCnt` (6b) and `fx`.

**IDLE**
- A bonus pulse moves the channel to ACTIVE with `secLeft=EFFECT_SEC`, `frameCnt=0`, `stack=0`, `fx=1`.
- `start_of_frame` and hit pulses are ignored.

**ACTIVE/WARN, per-second tick**
- On each `start_of_frame`, `frameCnt` increments.
- When `frameCnt==SOF_PER_SEC-1`, `frameCnt` returns to 0 and `secLeft` decrements. This decrement is the "second tick".

**Entering WARN**
- A second tick that yields 0 < `secLeft` ≤ `WARN_SEC` while in ACTIVE moves the channel to WARN.
- On entry: `flashCnt=0`, `fx=1`.
- In WARN, each `start_of_frame` increments `flashCnt`. When `flashCnt==FLASH_FRAMES-1`, `flashCnt` returns to 0 and `fx` toggles.

**Expiry** (a second tick that yields `secLeft` 0)
- If `stack>0`: `stack` decrements, `secLeft=EFFECT_SEC`, state becomes ACTIVE, `fx=1`.
- Otherwise: state becomes IDLE, `fx=0`, `secLeft=0`.

**Bonus while ACTIVE/WARN**
- If `stack<MAX_STACK`, `stack` increments. Otherwise the bonus is dropped silently.

**Hit while ACTIVE/WARN**
- Next state is IDLE. `stack`, `secLeft`, `frameCnt`, `flashCnt` and `fx` all clear.

**Priority in one cycle:** hit > expiry > bonus > tick.
- Hit together with bonus: the channel goes to IDLE and the bonus is lost.
- Expiry together with bonus: reload `secLeft=EFFECT_SEC`, go to ACTIVE. `stack` is unchanged (the bonus is consumed directly by the reload).
- Bonus together with a non-expiring tick: both apply.
- Bonus in IDLE together with `start_of_frame`: the load wins, `frameCnt=0`.

**Arithmetic:** all counters are unsigned. Counters never wrap: `stack` saturates at `MAX_STACK` and `secLeft` never decrements below 0.

## Timing
- Every output is registered and changes on the rising edge after the causing input.
- A bonus pulse at edge N gives `Shield=1`, `ShieldFx=1`, `SecLeft=EFFECT_SEC` after edge N+1.
- Effect length with no stacking and no hit: exactly `EFFECT_SEC*SOF_PER_SEC` frame ticks. It ends on the edge that samples the last tick.
- A hit is visible one cycle later.
- Reset, including mid-effect, asynchronously forces every output to 0 and every FSM to IDLE.
- Inputs are assumed synchronous to `clk`. Pulses wider than one cycle count once per high cycle (no edge detection).

## Structure
- Package `bonus_effect_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACTIVE, WARN} bonus_state_t`
  - localparams `SEC_W=5`, `FRAME_W=6`, `STACK_W=2`
- Sub-module `bonus_effect_channel`: one tank, same parameters, ports `start_of_frame`, `bonusIn`, `hit`, `shield`, `shieldFx`, `secLeft`, `stack`.
- Top level instantiates the channel twice and wires the ports. There is no shared state between channels.

## Test plan
The bench overrides `SOF_PER_SEC=2`, `EFFECT_SEC=4`, `WARN_SEC=2`, `FLASH_FRAMES=1`, `MAX_STACK=2`.
1. Single `tank1BonusIn` pulse, then 8 frame ticks:
   - Shield is 1 for exactly 8 ticks.
   - `SecLeft` steps 4,3,2,1,0.
   - WARN is entered at `SecLeft=2`, after which `ShieldFx` toggles every tick.
   - Shield is 0 after tick 8. Tank2 outputs stay 0 throughout.
2. Three bonuses while ACTIVE:
   - `Stack` goes 1, 2, then stays 2 (saturation).
   - Total shield duration is 24 ticks, with reloads to `SecLeft=4` at ticks 8 and 16.
3. Bonus on the same cycle as the expiring tick:
   - `SecLeft=4`, state ACTIVE, `Stack` unchanged at 0, Shield never drops.
4. Hit and bonus on the same cycle while ACTIVE with `Stack=1`:
   - Next cycle has Shield=0, `ShieldFx=0`, `Stack=0`, `SecLeft=0`.
5. Simultaneous `tank1BonusIn` and `tank2BonusIn`, then `tank2Hit` at tick 3:
   - Tank1 runs the full 8 ticks.
   - Tank2 clears one cycle after the hit.
6. `resetN` asserted low mid-WARN, asynchronously between edges:
   - All outputs are 0 immediately.
   - After release, a new bonus restarts cleanly at `SecLeft=4`.
